mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the single shared cache/memory port between the instruction-fetch requester (I-side, read-only) and the load/store reservation station (D-side, read/write). The arbiter grants one requester, registers its command, drives the shared port until `mem_resp`, and routes the response back to the granted requester. Ties are broken round-robin so neither side starves. It sits between fetch/LDST and the cache.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (byte enable is `DATA_W/8`)

- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `i_read`  in  1  I-side read request, level, held until `i_resp`
- `i_address`  in  ADDR_W  I-side address
- `i_resp`  out  1  I-side response, 1-cycle pulse
- `i_rdata`  out  DATA_W  I-side read data, valid with `i_resp`
- `d_read`  in  1  D-side read request, level, held until `d_resp`
- `d_write`  in  1  D-side write request, level, held until `d_resp`
- `d_address`  in  ADDR_W  D-side address
- `d_wdata`  in  DATA_W  D-side write data
- `d_byte_enable`  in  DATA_W/8  D-side byte enables
- `d_resp`  out  1  D-side response, 1-cycle pulse
- `d_rdata`  out  DATA_W  D-side read data, valid with `d_resp`
- `mem_read`  out  1  shared-port read
- `mem_write`  out  1  shared-port write
- `mem_address`  out  ADDR_W  shared-port address, bits [1:0] forced 0
- `mem_wdata`  out  DATA_W  shared-port write data
- `mem_byte_enable`  out  DATA_W/8  shared-port byte enables
- `mem_resp`  in  1  shared-port completion
- `mem_rdata`  in  DATA_W  shared-port read data
- `busy`  out  1  high while a grant is outstanding

## Operation
- FSM states: `IDLE`, `I_GNT`, `D_GNT`. Register `last_d` records the most recent grant (1 = D-side).
- `IDLE`: `mem_read`/`mem_write` = 0. Requests are evaluated as follows:
  - Only I-side requesting -> `I_GNT`.
  - Only D-side requesting (`d_read|d_write`) -> `D_GNT`.
  - Both requesting -> `D_GNT` if `last_d`=0, else `I_GNT`.
  - On the transition, the granted requester's address, wdata, byte enables and op are captured into command registers, and `last_d` is updated.
- I-side capture: op = read, byte enable = all ones, wdata = 0.
- D-side capture: if `d_read` and `d_write` are both high, the write wins (illegal input, must not hang).
- `I_GNT`/`D_GNT`:
  - `mem_*` are driven only from the command registers, so requester input changes after grant are ignored.
  - On `mem_resp`: assert `i_resp` or `d_resp` in the same cycle (combinational from `mem_resp` and state), then go to `IDLE`.
- `i_rdata` = `d_rdata` = `mem_rdata` always; consumers qualify the data with their resp.
- `mem_resp` in `IDLE` is ignored: no resp is issued and no state changes.
- `busy` = state != `IDLE`.

## Timing
- Reset (async): state=`IDLE`, `last_d`=0, command registers=0. All outputs are 0: `mem_read`, `mem_write`, `mem_address`, `mem_wdata`, `mem_byte_enable`, `i_resp`, `d_resp`, `busy`.
- Reset mid-transaction drops `mem_read`/`mem_write` immediately. A late `mem_resp` after reset is ignored.
- Grant latency: a request visible in `IDLE` at edge N drives `mem_read`/`mem_write` starting at cycle N+1.
- A resp at cycle M returns the FSM to `IDLE` at M+1. The next `mem_*` op starts at M+2 at the earliest, so there is one mandatory bubble cycle.
- A single-cycle memory (resp in the first grant cycle) yields exactly 1 op cycle.
- Requesters deassert their request the cycle after resp. A request still high in `IDLE` at M+1 is treated as a new request.
- Only one of `i_resp`/`d_resp` is ever high in a cycle. `mem_read` and `mem_write` are never both high.

## Test plan
- I-only: `i_read`=1, `i_address`=0x0000_1006, resp after 3 cycles -> `mem_read`=1 for 3 cycles, `mem_address`=0x0000_1004, `mem_byte_enable`=4'hF, `i_resp` pulse with `i_rdata`=`mem_rdata`=0xDEAD_BEEF.
- D write: `d_write`=1, addr 0x200, wdata 0x1234_5678, be 4'b0011 -> `mem_write`=1 with those values held until `mem_resp`, `d_resp` pulse, `i_resp` stays 0.
- Tie round-robin: `i_read` and `d_read` both held from reset -> order of grants is D, I, D, I. Each op is separated by exactly one `IDLE` bubble.
- Input change after grant: change `d_address` from 0x100 to 0x300 during `D_GNT` -> `mem_address` stays 0x100 until resp.
- Stray resp: pulse `mem_resp` in `IDLE` -> no `i_resp`/`d_resp`, state remains `IDLE`.
- Async reset mid-op: assert `rst` during `I_GNT` between edges -> `mem_read`=0 immediately, `busy`=0. After release, the next tie grants D first.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles the I-side, D-side and shared memory port signals of the port arbiter.
// The arbiter uses the master view; requesters and memory together use the slave view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  i_read;
    logic [ADDR_W-1:0]     i_address;
    logic                  i_resp;
    logic [DATA_W-1:0]     i_rdata;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_W-1:0]     d_address;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_byte_enable;
    logic                  d_resp;
    logic [DATA_W-1:0]     d_rdata;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_W-1:0]     mem_address;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_byte_enable;
    logic                  mem_resp;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  busy;

    modport master (
        input  i_read, i_address,
        input  d_read, d_write, d_address, d_wdata, d_byte_enable,
        input  mem_resp, mem_rdata,
        output i_resp, i_rdata, d_resp, d_rdata,
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output busy
    );

    modport slave (
        output i_read, i_address,
        output d_read, d_write, d_address, d_wdata, d_byte_enable,
        output mem_resp, mem_rdata,
        input  i_resp, i_rdata, d_resp, d_rdata,
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one cache/memory port between instruction fetch (read-only)
// and load/store (read/write). The granted command is registered and held until mem_resp.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.master  bus
);
    localparam int unsigned BE_W = DATA_W / 8;

    typedef enum logic [1:0] {StIdle, StIGnt, StDGnt} state_e;

    state_e              r_state;
    logic                r_last_d;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_be;

    logic w_i_req;
    logic w_d_req;
    logic w_pick_d;

    assign w_i_req  = bus.i_read;
    assign w_d_req  = bus.d_read | bus.d_write;
    // On a tie, serve whichever side did not get the previous grant.
    assign w_pick_d = w_d_req & (~w_i_req | ~r_last_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_last_d    <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_pick_d) begin
                        r_state     <= StDGnt;
                        r_last_d    <= 1'b1;
                        // Simultaneous read and write is illegal; the write wins.
                        r_mem_read  <= ~bus.d_write;
                        r_mem_write <= bus.d_write;
                        r_addr      <= {bus.d_address[ADDR_W-1:2], 2'b00};
                        r_wdata     <= bus.d_wdata;
                        r_be        <= bus.d_byte_enable;
                    end else if (w_i_req) begin
                        r_state     <= StIGnt;
                        r_last_d    <= 1'b0;
                        r_mem_read  <= 1'b1;
                        r_mem_write <= 1'b0;
                        r_addr      <= {bus.i_address[ADDR_W-1:2], 2'b00};
                        r_wdata     <= '0;
                        r_be        <= '1;
                    end
                end
                StIGnt, StDGnt: begin
                    if (bus.mem_resp) begin
                        r_state     <= StIdle;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_read        = r_mem_read;
    assign bus.mem_write       = r_mem_write;
    assign bus.mem_address     = r_addr;
    assign bus.mem_wdata       = r_wdata;
    assign bus.mem_byte_enable = r_be;

    assign bus.i_resp  = bus.mem_resp & (r_state == StIGnt);
    assign bus.d_resp  = bus.mem_resp & (r_state == StDGnt);
    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;
    assign bus.busy    = (r_state != StIdle);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: requester tasks and a latency-randomised memory drive the DUT;
// a transaction-level grant model feeds an expectation queue consumed by a negedge monitor.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        bit          d;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    bit          cur_valid;
    int unsigned cyc;
    int          n_vec;
    int          n_err;
    int unsigned force_lat;
    logic [31:0] rd_v;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference model: the port is either free or owned by one side; a free port is handed
    // to a requester at the next edge, alternating between the two sides when both ask.
    bit free_m;
    bit last_d_m;
    initial begin
        free_m   = 1'b1;
        last_d_m = 1'b0;
        cyc      = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                free_m    = 1'b1;
                last_d_m  = 1'b0;
                cur_valid = 1'b0;
                exp_q.delete();
            end else if (free_m) begin
                bit ireq;
                bit dreq;
                bit give_d;
                exp_t e;
                ireq = bus.i_read;
                dreq = bus.d_read | bus.d_write;
                if (ireq || dreq) begin
                    give_d = (dreq && !ireq) || (dreq && ireq && !last_d_m);
                    e.cyc  = cyc;
                    e.d    = give_d;
                    if (give_d) begin
                        e.wr    = bus.d_write;
                        e.addr  = bus.d_address & 32'hFFFF_FFFC;
                        e.wdata = bus.d_wdata;
                        e.be    = bus.d_byte_enable;
                    end else begin
                        e.wr    = 1'b0;
                        e.addr  = bus.i_address & 32'hFFFF_FFFC;
                        e.wdata = 32'h0;
                        e.be    = 4'hF;
                    end
                    exp_q.push_back(e);
                    last_d_m = give_d;
                    free_m   = 1'b0;
                end
            end else if (bus.mem_resp) begin
                free_m = 1'b1;
            end
        end
    end

    // Memory: answers each op after 1..4 cycles (or force_lat), with stray resps when idle.
    initial begin
        int unsigned cnt;
        int unsigned lat;
        cnt = 0;
        lat = 1;
        forever begin
            @(posedge clk);
            #1;
            if ((bus.mem_read || bus.mem_write) && !rst) begin
                if (cnt == 0) lat = (force_lat != 0) ? force_lat : $urandom_range(1, 4);
                cnt++;
                if (cnt >= lat) begin
                    rd_v         = $urandom;
                    bus.mem_resp = 1'b1;
                    cnt          = 0;
                end else begin
                    bus.mem_resp = 1'b0;
                end
            end else begin
                cnt          = 0;
                rd_v         = $urandom;
                bus.mem_resp = ($urandom_range(0, 7) == 0);
            end
            bus.mem_rdata = rd_v;
        end
    end

    // Monitor: pops the expected grant in the cycle it must appear and checks every output.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                bit exp_ir;
                bit exp_dr;
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    cur       = exp_q.pop_front();
                    cur_valid = 1'b1;
                end
                chk("mem_read", 64'(bus.mem_read), 64'(cur_valid && !cur.wr));
                chk("mem_write", 64'(bus.mem_write), 64'(cur_valid && cur.wr));
                chk("busy", 64'(bus.busy), 64'(cur_valid));
                if (cur_valid) begin
                    chk("mem_address", 64'(bus.mem_address), 64'(cur.addr));
                    chk("mem_wdata", 64'(bus.mem_wdata), 64'(cur.wdata));
                    chk("mem_byte_enable", 64'(bus.mem_byte_enable), 64'(cur.be));
                end
                exp_ir = cur_valid && bus.mem_resp && !cur.d;
                exp_dr = cur_valid && bus.mem_resp && cur.d;
                chk("i_resp", 64'(bus.i_resp), 64'(exp_ir));
                chk("d_resp", 64'(bus.d_resp), 64'(exp_dr));
                if (exp_ir) chk("i_rdata", 64'(bus.i_rdata), 64'(rd_v));
                if (exp_dr) chk("d_rdata", 64'(bus.d_rdata), 64'(rd_v));
                if (cur_valid && bus.mem_resp) cur_valid = 1'b0;
            end
        end
    end

    task automatic req_i(input logic [31:0] a, input bit mutate);
        bit got;
        got          = 1'b0;
        bus.i_read   = 1'b1;
        bus.i_address = a;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (bus.i_resp) got = 1'b1;
            else if (mutate && $urandom_range(0, 3) == 0) bus.i_address = $urandom;
        end
        if (!got) chk("i_resp_timeout", 64'(got), 64'(1));
        @(posedge clk);
        #1;
        bus.i_read = 1'b0;
    endtask

    task automatic req_d(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be, input bit mutate);
        bit got;
        got               = 1'b0;
        bus.d_read        = rd;
        bus.d_write       = wr;
        bus.d_address     = a;
        bus.d_wdata       = wd;
        bus.d_byte_enable = be;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (bus.d_resp) got = 1'b1;
            else if (mutate && $urandom_range(0, 3) == 0) begin
                bus.d_address = $urandom;
                bus.d_wdata   = $urandom;
            end
        end
        if (!got) chk("d_resp_timeout", 64'(got), 64'(1));
        @(posedge clk);
        #1;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
    endtask

    task automatic req_d_rand(input bit mutate);
        int unsigned r;
        r = $urandom_range(0, 9);
        req_d((r == 0) || (r < 5), (r == 0) || (r >= 5), $urandom, $urandom,
              4'($urandom_range(0, 15)), mutate);
    endtask

    task automatic idle_gap();
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit seen;
        n_vec             = 0;
        n_err             = 0;
        force_lat         = 0;
        cur_valid         = 1'b0;
        rd_v              = '0;
        bus.i_read        = 1'b0;
        bus.i_address     = '0;
        bus.d_read        = 1'b0;
        bus.d_write       = 1'b0;
        bus.d_address     = '0;
        bus.d_wdata       = '0;
        bus.d_byte_enable = '0;
        bus.mem_resp      = 1'b0;
        bus.mem_rdata     = '0;
        rst               = 1'b1;

        #1;
        chk("rst_mem_read", 64'(bus.mem_read), 64'(0));
        chk("rst_mem_write", 64'(bus.mem_write), 64'(0));
        chk("rst_mem_address", 64'(bus.mem_address), 64'(0));
        chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
        chk("rst_mem_byte_enable", 64'(bus.mem_byte_enable), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_i_resp", 64'(bus.i_resp), 64'(0));
        chk("rst_d_resp", 64'(bus.d_resp), 64'(0));
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;

        // Directed transactions.
        @(posedge clk);
        #1;
        force_lat = 3;
        req_i(32'h0000_1006, 1'b0);
        force_lat = 0;
        idle_gap();
        req_d(1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'b0011, 1'b0);
        idle_gap();
        force_lat = 4;
        fork
            req_d(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 1'b0);
            begin
                repeat (2) @(negedge clk);
                bus.d_address = 32'h0000_0300;
            end
        join
        force_lat = 0;
        idle_gap();
        req_d(1'b1, 1'b1, 32'h0000_0444, 32'hCAFE_F00D, 4'b1100, 1'b0);
        idle_gap();
        repeat (2) begin
            fork
                req_i(32'h0000_2000, 1'b0);
                req_d(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'hF, 1'b0);
            join
        end

        // Asynchronous reset in the middle of an I-side grant.
        repeat (3) @(posedge clk);
        #1;
        force_lat     = 8;
        bus.i_read    = 1'b1;
        bus.i_address = 32'h0000_0040;
        seen          = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.mem_read) seen = 1'b1;
        end
        chk("pre_reset_grant", 64'(seen), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("midop_rst_mem_read", 64'(bus.mem_read), 64'(0));
        chk("midop_rst_busy", 64'(bus.busy), 64'(0));
        chk("midop_rst_i_resp", 64'(bus.i_resp), 64'(0));
        bus.i_read = 1'b0;
        @(posedge clk);
        #3;
        rst       = 1'b0;
        force_lat = 0;
        @(posedge clk);
        #1;
        fork
            req_i(32'h0000_5000, 1'b0);
            req_d(1'b0, 1'b1, 32'h0000_6000, 32'h5555_AAAA, 4'hF, 1'b0);
        join

        // Randomised concurrent traffic, with inputs wandering after grant.
        fork
            repeat (40) begin
                idle_gap();
                req_i($urandom, $urandom_range(0, 1) == 1);
            end
            repeat (40) begin
                idle_gap();
                req_d_rand($urandom_range(0, 1) == 1);
            end
        join

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("pending_grants", 64'(exp_q.size()), 64'(0));
        chk("final_busy", 64'(bus.busy), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
